// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and burst helpers for the byte-wide masters.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR = 3'b001;
  localparam logic [2:0] HBURST_WRAP4 = 3'b010;
  localparam logic [2:0] HBURST_INCR4 = 3'b011;
  localparam logic [2:0] HBURST_WRAP8 = 3'b100;
  localparam logic [2:0] HBURST_INCR8 = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_BURST, ST_LAST} state_t;
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst, input logic [4:0] len, input logic [4:0] lim);
    return hburst == HBURST_SINGLE ? 5'd1 :
           hburst == HBURST_INCR ? (len == 5'd0 ? 5'd1 : len > lim ? lim : len) :
           hburst[2:1] == 2'b01 ? 5'd4 : hburst[2:1] == 2'b10 ? 5'd8 : 5'd16;
  endfunction
  // Zero mask means linear addressing; otherwise the low bits wrap inside the mask.
  function automatic logic [3:0] wrap_mask(input logic [2:0] hburst);
    return (hburst[0] || hburst == HBURST_SINGLE) ? 4'h0 :
           hburst[2:1] == 2'b01 ? 4'h3 : hburst[2:1] == 2'b10 ? 4'h7 : 4'hF;
  endfunction
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: combinational beat address from burst base, beat index and hburst.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        beat,
  input  logic [2:0]        hburst,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] mask, lin;
  always_comb begin
    mask = ADDR_W'(wrap_mask(hburst));
    lin = base + ADDR_W'(beat);
    addr = mask == '0 ? lin : (base & ~mask) | (lin & mask);
  end
endmodule

// File: rtl/ahb_master_ctrl.sv
// ahb_master_ctrl: AHB-Lite byte master running single/INCR/WRAP bursts from a command handshake.
module ahb_master_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int INCR_MAX = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic [1:0]        htrans,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);
  state_t state;
  logic [ADDR_W-1:0] base, next_addr;
  logic [4:0] nbeats, beat;
  logic dvalid, abort;
  assign abort = dvalid && hresp;
  assign wdata_pop = htrans[1] && hwrite && hready && !abort;
  assign hsize = HSIZE_BYTE;
  assign hprot = HPROT_DEFAULT;
  assign hmastlock = 1'b0;
  ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base(base),
    .beat(beat + 5'd1),
    .hburst(hburst),
    .addr(next_addr)
  );
  // dvalid marks a data phase in flight; an error there abandons the rest of the burst.
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state <= ST_IDLE;
      cmd_ready <= 1'b0;
      base <= '0;
      nbeats <= '0;
      beat <= '0;
      dvalid <= 1'b0;
      haddr <= '0;
      htrans <= HTRANS_IDLE;
      hsel <= 1'b0;
      hwrite <= 1'b0;
      hburst <= '0;
      hwdata <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      if (state == ST_IDLE) begin
        cmd_ready <= !(cmd_valid && cmd_ready);
        if (cmd_valid && cmd_ready) begin
          state <= ST_ADDR;
          base <= cmd_addr;
          nbeats <= burst_beats(cmd_burst, cmd_len, 5'(INCR_MAX));
          beat <= '0;
          haddr <= cmd_addr;
          htrans <= HTRANS_NONSEQ;
          hsel <= 1'b1;
          hwrite <= cmd_write;
          hburst <= cmd_burst;
        end
      end else if (abort) begin
        state <= ST_IDLE;
        cmd_ready <= 1'b1;
        htrans <= HTRANS_IDLE;
        hsel <= 1'b0;
        dvalid <= 1'b0;
        done <= 1'b1;
        err <= 1'b1;
      end else if (hready) begin
        dvalid <= htrans[1];
        if (dvalid && !hwrite) begin
          rdata <= hrdata;
          rdata_valid <= 1'b1;
        end
        if (wdata_pop) hwdata <= wdata;
        if (state == ST_LAST) begin
          state <= ST_IDLE;
          cmd_ready <= 1'b1;
          hsel <= 1'b0;
          done <= 1'b1;
        end else if (beat == nbeats - 5'd1) begin
          state <= ST_LAST;
          htrans <= HTRANS_IDLE;
        end else begin
          state <= ST_BURST;
          beat <= beat + 5'd1;
          haddr <= next_addr;
          htrans <= HTRANS_SEQ;
        end
      end
    end
endmodule
